// File: rtl/lc3b_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_bridge_pkg
// Purpose  : Shared types for the LC-3b word-to-line memory bridge: line and
//            word-offset types, the write-lane mask and the bridge state enum.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lc3b_mem_bridge_pkg;

    // log2 of the physical line size in bytes (16 bytes = 8 words)
    localparam int LC3B_OFFSET_BITS = 4;
    localparam int LC3B_LINE_W      = 8 * (2 ** LC3B_OFFSET_BITS);

    typedef logic [15:0]                 lc3b_word;
    typedef logic [LC3B_LINE_W-1:0]      lc3b_line;
    typedef logic [LC3B_OFFSET_BITS-2:0] lc3b_word_offset;
    typedef logic [1:0]                  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_LINE = 2'd1,
        WR_LINE = 2'd2,
        RESP    = 2'd3
    } bridge_state_e;

endpackage
`default_nettype wire

// File: rtl/lc3b_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_bridge_if
// Purpose  : Bundles the CPU-side word request bus and the physical-memory
//            line bus seen by the bridge.
// Ports    : CPU side  - mem_read, mem_write, mem_byte_enable, mem_address,
//                        mem_wdata, mem_rdata, mem_resp
//            pmem side - pmem_read, pmem_write, pmem_address, pmem_wdata,
//                        pmem_rdata, pmem_resp
//            modport slave  : the bridge
//            modport master : the environment (CPU + physical memory)
// Revision : 1.0 - initial release
// ============================================================================
interface lc3b_mem_bridge_if
    import lc3b_mem_bridge_pkg::*;
#(
    parameter int OFFSET_BITS = LC3B_OFFSET_BITS
);
    localparam int LINE_W = 8 * (2 ** OFFSET_BITS);

    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_byte_enable;
    logic [15:0]       mem_address;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [15:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface
`default_nettype wire

// File: rtl/lc3b_mem_bridge_line_merge.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_bridge_line_merge
// Purpose  : Combinational line merge. Replaces one 16-bit word of a line
//            lane-by-lane: enabled bytes take wdata, others keep the line.
// Ports    : line_i     - original line
//            word_idx_i - index of the word to update
//            wdata_i    - write word
//            mask_i     - byte lanes (bit1 = [15:8], bit0 = [7:0])
//            line_o     - merged line
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_mem_bridge_line_merge
    import lc3b_mem_bridge_pkg::*;
#(
    parameter int OFFSET_BITS = LC3B_OFFSET_BITS
)(
    input  wire logic [8*(2**OFFSET_BITS)-1:0] line_i,
    input  wire logic [OFFSET_BITS-2:0]        word_idx_i,
    input  wire lc3b_word                      wdata_i,
    input  wire lc3b_mem_wmask                 mask_i,
    output logic      [8*(2**OFFSET_BITS)-1:0] line_o
);
    localparam int WORDS  = 2 ** (OFFSET_BITS - 1);
    localparam int WIDX_W = OFFSET_BITS - 1;

    always_comb begin
        line_o = line_i;
        for (int w = 0; w < WORDS; w++) begin
            if (word_idx_i == WIDX_W'(w)) begin
                if (mask_i[0]) line_o[w*16 +: 8]     = wdata_i[7:0];
                if (mask_i[1]) line_o[w*16 + 8 +: 8] = wdata_i[15:8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lc3b_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_bridge
// Purpose  : Converts CPU 16-bit word reads/writes into whole-line physical
//            memory transactions. Writes are read-modify-write of the line.
// Ports    : clk   - system clock
//            reset - synchronous, active-high
//            bus   - lc3b_mem_bridge_if.slave (CPU request bus + pmem bus)
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_mem_bridge
    import lc3b_mem_bridge_pkg::*;
#(
    parameter int OFFSET_BITS = LC3B_OFFSET_BITS
)(
    input  wire logic         clk,
    input  wire logic         reset,
    lc3b_mem_bridge_if.slave  bus
);
    localparam int LINE_W = 8 * (2 ** OFFSET_BITS);

    bridge_state_e        state_q;
    logic                 is_write_q;
    logic [15:1]          addr_q;      // byte address bit 0 is never used
    lc3b_word             wdata_q;
    lc3b_mem_wmask        mask_q;
    logic [LINE_W-1:0]    line_q;
    lc3b_word             rdata_q;
    logic                 resp_q;
    logic                 pmem_read_q;
    logic                 pmem_write_q;

    logic [OFFSET_BITS-2:0] word_idx;
    logic [OFFSET_BITS+2:0] word_base;  // bit position of the selected word
    logic [LINE_W-1:0]      merged_line;
    logic                   unused_addr_lsb;

    assign word_idx        = addr_q[OFFSET_BITS-1:1];
    assign word_base       = {word_idx, 4'b0000};
    assign unused_addr_lsb = bus.mem_address[0];

    lc3b_mem_bridge_line_merge #(
        .OFFSET_BITS (OFFSET_BITS)
    ) u_line_merge (
        .line_i     (line_q),
        .word_idx_i (word_idx),
        .wdata_i    (wdata_q),
        .mask_i     (mask_q),
        .line_o     (merged_line)
    );

    assign bus.mem_rdata    = rdata_q;
    assign bus.mem_resp     = resp_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = {addr_q[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign bus.pmem_wdata   = merged_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            line_q       <= '0;
            rdata_q      <= '0;
            resp_q       <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_write || bus.mem_read) begin
                        addr_q      <= bus.mem_address[15:1];
                        wdata_q     <= bus.mem_wdata;
                        mask_q      <= bus.mem_byte_enable;
                        // write wins when both requests are raised
                        is_write_q  <= bus.mem_write;
                        pmem_read_q <= 1'b1;
                        state_q     <= RD_LINE;
                    end
                end
                RD_LINE: begin
                    if (bus.pmem_resp) begin
                        line_q      <= bus.pmem_rdata;
                        pmem_read_q <= 1'b0;
                        if (is_write_q) begin
                            pmem_write_q <= 1'b1;
                            state_q      <= WR_LINE;
                        end else begin
                            rdata_q <= bus.pmem_rdata[word_base +: 16];
                            resp_q  <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                WR_LINE: begin
                    if (bus.pmem_resp) begin
                        pmem_write_q <= 1'b0;
                        resp_q       <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    resp_q       <= 1'b0;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3b_mem_bridge
// Purpose  : Self-checking bench for lc3b_mem_bridge with a physical memory
//            model of programmable latency and a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lc3b_mem_bridge_if #(.OFFSET_BITS(4)) bus ();

    lc3b_mem_bridge #(.OFFSET_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // physical memory contents, indexed by line address
    logic [127:0] mem [logic [15:0]];
    int           lat = 1;
    int           pcnt = 0;

    logic [15:0]  exp_addr_q  [$];
    logic [127:0] exp_wline_q [$];
    logic [15:0]  exp_rdata_q [$];
    logic [15:0]  last_rdata = 16'h0000;

    function automatic logic [127:0] line_of(input logic [15:0] la);
        if (mem.exists(la)) return mem[la];
        return '0;
    endfunction

    function automatic logic [127:0] merge_ref(input logic [127:0] ln, input logic [15:0] a,
                                               input logic [15:0] wd, input logic [1:0] m);
        logic [127:0] r;
        int           w;
        r = ln;
        w = int'(a[3:1]);
        if (m[0]) r[w*16 +: 8]     = wd[7:0];
        if (m[1]) r[w*16 + 8 +: 8] = wd[15:8];
        return r;
    endfunction

    // Physical memory: responds in the lat-th cycle its request is asserted
    always @(negedge clk) begin
        logic [15:0] la;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (reset || !(bus.pmem_read || bus.pmem_write)) begin
            pcnt = 0;
        end else begin
            pcnt++;
            if (pcnt == lat) begin
                pcnt = 0;
                bus.pmem_resp = 1'b1;
                chk("pmem_excl", {127'd0, bus.pmem_read & bus.pmem_write}, 128'd0);
                if (exp_addr_q.size() == 0) begin
                    chk("sb_addr_empty", 128'd1, 128'd0);
                    la = bus.pmem_address;
                end else begin
                    la = exp_addr_q.pop_front();
                    chk("pmem_addr", {112'd0, bus.pmem_address}, {112'd0, la});
                end
                if (bus.pmem_read) begin
                    bus.pmem_rdata = line_of(la);
                end else if (exp_wline_q.size() == 0) begin
                    chk("sb_wline_empty", 128'd1, 128'd0);
                end else begin
                    logic [127:0] el;
                    el = exp_wline_q.pop_front();
                    chk("pmem_wdata", bus.pmem_wdata, el);
                    mem[la] = el;
                end
            end
        end
    end

    task automatic do_req(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] wd,
                          input logic [1:0] m, input int L, input bit hold);
        logic [15:0]  la;
        logic [127:0] ln;
        int           c;
        la  = {a[15:4], 4'h0};
        ln  = line_of(la);
        lat = L;
        bus.mem_write       = wr;
        bus.mem_read        = rd;
        bus.mem_address     = a;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = m;
        exp_addr_q.push_back(la);
        if (wr) begin
            exp_addr_q.push_back(la);
            exp_wline_q.push_back(merge_ref(ln, a, wd, m));
        end else begin
            exp_rdata_q.push_back(ln[int'(a[3:1])*16 +: 16]);
        end
        c = 0;
        while (c < 200) begin
            @(negedge clk); #1;
            c++;
            if (c == 1) begin
                // request is latched; disturb the data-side inputs
                bus.mem_address     = 16'($urandom);
                bus.mem_wdata       = 16'($urandom);
                bus.mem_byte_enable = 2'($urandom);
            end
            if (bus.mem_resp) break;
        end
        if (!bus.mem_resp) begin
            chk("resp_timeout", 128'd0, 128'd1);
        end else begin
            chk("latency", 128'(c), wr ? 128'(2*L + 1) : 128'(L + 1));
            if (!wr) begin
                if (exp_rdata_q.size() == 0) begin
                    chk("sb_rdata_empty", 128'd1, 128'd0);
                end else begin
                    last_rdata = exp_rdata_q.pop_front();
                    chk("mem_rdata", {112'd0, bus.mem_rdata}, {112'd0, last_rdata});
                end
            end else begin
                chk("rdata_hold", {112'd0, bus.mem_rdata}, {112'd0, last_rdata});
            end
        end
        if (!hold) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
        @(negedge clk); #1;
        chk("resp_pulse", {127'd0, bus.mem_resp}, 128'd0);
    endtask

    initial begin
        int c;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 16'h0;
        bus.mem_wdata       = 16'h0;
        bus.mem_byte_enable = 2'b00;
        for (int i = 0; i < 8; i++) mem[16'h3000][i*16 +: 16] = 16'h5000 + 16'(i);
        mem[16'h3000][5*16 +: 16] = 16'hBEEF;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_resp",   {127'd0, bus.mem_resp},   128'd0);
        chk("rst_pmem_read",  {127'd0, bus.pmem_read},  128'd0);
        chk("rst_pmem_write", {127'd0, bus.pmem_write}, 128'd0);
        chk("rst_mem_rdata",  {112'd0, bus.mem_rdata},  128'd0);
        chk("rst_pmem_addr",  {112'd0, bus.pmem_address}, 128'd0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 128'd0);
        reset = 1'b0;
        @(negedge clk); #1;

        // read, L=3
        do_req(1'b0, 1'b1, 16'h300A, 16'h0, 2'b00, 3, 1'b0);
        // word write, L=2
        mem[16'h0020] = {8{16'h1111}};
        do_req(1'b1, 1'b0, 16'h0024, 16'hCAFE, 2'b11, 2, 1'b0);
        chk("wr_word_commit", mem[16'h0020], {{5{16'h1111}}, 16'hCAFE, {2{16'h1111}}});
        // byte writes
        mem[16'h0020] = {8{16'h1111}};
        do_req(1'b1, 1'b0, 16'h0025, 16'hAB00, 2'b10, 2, 1'b0);
        mem[16'h0020] = {8{16'h1111}};
        do_req(1'b1, 1'b0, 16'h0025, 16'h00CD, 2'b01, 2, 1'b0);
        // both requests high: write sequence
        mem[16'h0040] = {8{16'h2222}};
        do_req(1'b1, 1'b1, 16'h0040, 16'h1234, 2'b11, 1, 1'b0);
        // mask 00 writes back the line unchanged
        do_req(1'b1, 1'b0, 16'h3006, 16'hFFFF, 2'b00, 2, 1'b0);
        // back-to-back reads with mem_read held, last word of line included
        do_req(1'b0, 1'b1, 16'h3002, 16'h0, 2'b00, 1, 1'b1);
        do_req(1'b0, 1'b1, 16'h300E, 16'h0, 2'b00, 4, 1'b1);
        do_req(1'b0, 1'b1, 16'h300B, 16'h0, 2'b00, 2, 1'b0);

        // reset while pmem_resp is high in WR_LINE
        lat = 2;
        mem[16'h0060] = {8{16'h3333}};
        bus.mem_write       = 1'b1;
        bus.mem_address     = 16'h0066;
        bus.mem_wdata       = 16'h7777;
        bus.mem_byte_enable = 2'b11;
        exp_addr_q.push_back(16'h0060);
        exp_addr_q.push_back(16'h0060);
        exp_wline_q.push_back(merge_ref(mem[16'h0060], 16'h0066, 16'h7777, 2'b11));
        c = 0;
        while (c < 100) begin
            @(negedge clk); #1;
            c++;
            if (bus.pmem_write && bus.pmem_resp) break;
        end
        chk("wr_line_reached", {127'd0, bus.pmem_write & bus.pmem_resp}, 128'd1);
        reset         = 1'b1;
        bus.mem_write = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_pmem_write", {127'd0, bus.pmem_write}, 128'd0);
        chk("rstmid_pmem_read",  {127'd0, bus.pmem_read},  128'd0);
        chk("rstmid_mem_resp",   {127'd0, bus.mem_resp},   128'd0);
        reset = 1'b0;
        last_rdata = 16'h0000;
        @(negedge clk); #1;
        chk("rstmid_resp_after", {127'd0, bus.mem_resp}, 128'd0);
        do_req(1'b0, 1'b1, 16'h0066, 16'h0, 2'b00, 2, 1'b0);

        chk("sb_drain", 128'(exp_addr_q.size() + exp_wline_q.size() + exp_rdata_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lc3b_mem_bridge.md
Name: lc3b_mem_bridge

Overview:
- Sits directly downstream of the multicycle control FSM and datapath.
- Turns the CPU's 16-bit word memory requests (mem_read/mem_write/mem_byte_enable, with address from MAR and write data from MDR) into whole-line transactions on a physical memory with a 2^OFFSET_BITS-byte line.
- Returns a single-cycle mem_resp and the selected word.
- Word and byte writes use read-modify-write on the containing line.

Parameters:
OFFSET_BITS, 4, log2 of line size in bytes; line = 8*2^OFFSET_BITS bits (default 128 bits = 8 words)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high
mem_read  input  1  CPU read request, held high until mem_resp
mem_write  input  1  CPU write request, held high until mem_resp
mem_byte_enable  input  2  write lane mask: bit1 = [15:8], bit0 = [7:0]
mem_address  input  16  CPU byte address; bit 0 ignored
mem_wdata  input  16  CPU write data
mem_rdata  output  16  selected word of the last line read
mem_resp  output  1  one-cycle completion pulse
pmem_read  output  1  physical line read, held until pmem_resp
pmem_write  output  1  physical line write, held until pmem_resp
pmem_address  output  16  line-aligned address: {addr[15:OFFSET_BITS], zeros}
pmem_wdata  output  8*2^OFFSET_BITS  merged line for write
pmem_rdata  input  8*2^OFFSET_BITS  line returned by physical memory
pmem_resp  input  1  physical completion, one cycle

Behaviour:
- Reset (sync, active-high): state IDLE; mem_resp, pmem_read, pmem_write = 0; mem_rdata = 0; latched address, wdata, mask and line = 0.
- Reset mid-transaction: next cycle the block is in IDLE with pmem_* deasserted and no mem_resp. A pmem_resp arriving that cycle is ignored.
- States: IDLE, RD_LINE, WR_LINE, RESP.
- IDLE:
  - When mem_write=1 or mem_read=1, latch mem_address, mem_wdata and mem_byte_enable, then go to RD_LINE. Latching captures request values, so later changes on the CPU-side inputs are ignored.
  - A write also sets an internal is_write flag.
  - mem_write has priority if both request inputs are high.
- RD_LINE:
  - pmem_read=1 and pmem_address = latched line address.
  - On pmem_resp, capture pmem_rdata into the line buffer.
  - Read: also load mem_rdata with word addr[OFFSET_BITS-1:1] of pmem_rdata, then go to RESP.
  - Write: go to WR_LINE.
- WR_LINE:
  - pmem_write=1, same pmem_address.
  - pmem_wdata = line buffer with word addr[OFFSET_BITS-1:1] replaced lane-by-lane: bytes whose enable bit is 1 take mem_wdata bytes, the others keep buffer bytes.
  - Mask 2'b00 is legal and rewrites the line unchanged.
  - On pmem_resp, go to RESP.
- RESP: mem_resp=1 for exactly one cycle, then IDLE. mem_rdata is not altered by writes and holds until the next read completes.
- Request sampling: requests are sampled only in IDLE. A CPU that still holds mem_read in the cycle after RESP starts a new transaction; this is allowed, since the FSM drops the request after seeing mem_resp.
- pmem_read and pmem_write are never both 1. Each is held constant until pmem_resp.
- Latency (physical memory responds in its Lth asserted cycle; request first seen in IDLE at cycle 0):
  - read: mem_resp at cycle L+1
  - write: mem_resp at cycle 2L+1
- Line offset wrap: no wrap; each transaction touches exactly one line. Word index 2^(OFFSET_BITS-1)-1 is the last word of the line.

Decomposition:
- lc3b_types additions: typedef lc3b_line (8*2^OFFSET_BITS bits), lc3b_word_offset, and the state enum for the bridge.
- One natural sub-module: lc3b_line_merge. It is combinational; inputs are line, word index, wdata and mask; output is the merged line. The same function serves a later cache.

Test Plan:
- Read, L=3: pmem line word[5]=16'hBEEF, mem_read at address 16'h300A → pmem_address 16'h3000; mem_resp one cycle at cycle 4; mem_rdata=16'hBEEF.
- Word write, L=2: line all 16'h1111, mem_write address 16'h0024, wdata 16'hCAFE, mask 2'b11 → pmem_read then pmem_write to 16'h0020 with word[2]=16'hCAFE, other words 16'h1111; mem_resp at cycle 5.
- Byte writes: address 16'h0025, wdata 16'hAB00, mask 2'b10 → word[2]=16'hAB11. Repeat with mask 2'b01, wdata 16'h00CD → word[2]=16'h11CD.
- Both requests high, reads after writes:
  - mem_read and mem_write both high → write sequence taken.
  - Two back-to-back reads with mem_read held → two distinct mem_resp pulses; mem_rdata updates each time.
  - mem_rdata unchanged across an intervening write.
- Reset asserted in WR_LINE while pmem_resp is high → next cycle IDLE, pmem_write=0, no mem_resp; a following read completes normally.
- Mask 2'b00 write → line written back identical to the line read; mem_resp still pulses once.
